// File: rtl/txn_guard_if.sv
// txn_guard_if: the request (AR/AW) and response (R/B) handshakes observed
// by txn_guard.
//   master : the traffic source side (drives every signal)
//   slave  : the guard side (observes every signal, drives nothing)
// Parameter IdWidth sets the AXI ID width.
interface txn_guard_if #(
  parameter int IdWidth = 4
) ();
  logic               req_valid;
  logic               req_ready;
  logic [IdWidth-1:0] req_id;
  logic [7:0]         req_len;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IdWidth-1:0] rsp_id;
  logic               rsp_last;

  modport master (
    output req_valid, req_ready, req_id, req_len,
    output rsp_valid, rsp_ready, rsp_id, rsp_last
  );

  modport slave (
    input req_valid, req_ready, req_id, req_len,
    input rsp_valid, rsp_ready, rsp_id, rsp_last
  );
endinterface

// File: rtl/txn_guard.sv
// txn_guard: AXI outstanding-transaction watchdog. Each accepted request
// (AR for Mode=0, AW for Mode=1) takes a slot with a cycle budget of
// budget_i*(len+1); a matching completion (R last / B) frees the oldest slot
// with that ID. Timeout, unexpected response or slot overflow raises a
// latched fault (reset_req_o) with a one-cycle irq_o; reset_clear_i re-arms.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   bus                 txn_guard_if.slave, observed handshakes
//   budget_i            cycles per beat (0 disables timeout for that request)
//   reset_clear_i       leave FAULT
//   reset_req_o, irq_o, irq_cause_o, irq_id_o   fault report
//   full_o, outstanding_o                       slot occupancy
//   latency_o, latency_valid_o, max_latency_o   completion latency report
// Define TXN_GUARD_LATENCY_EN to enable the latency report; otherwise those
// outputs are tied to 0.
module txn_guard #(
  parameter int MaxTxns  = 8,
  parameter int IdWidth  = 4,
  parameter int CntWidth = 16,
  parameter int Mode     = 0,
  localparam int OutW    = $clog2(MaxTxns + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  txn_guard_if.slave          bus,
  input  logic [CntWidth-1:0] budget_i,
  input  logic                reset_clear_i,
  output logic                reset_req_o,
  output logic                irq_o,
  output logic [1:0]          irq_cause_o,
  output logic [IdWidth-1:0]  irq_id_o,
  output logic                full_o,
  output logic [OutW-1:0]     outstanding_o,
  output logic [CntWidth-1:0] latency_o,
  output logic                latency_valid_o,
  output logic [CntWidth-1:0] max_latency_o
);

  typedef enum logic {MONITOR, FAULT} state_t;
  state_t state;

  logic [MaxTxns-1:0]                occ;
  logic [MaxTxns-1:0][IdWidth-1:0]   sid;
  logic [MaxTxns-1:0][CntWidth-1:0]  ela;
  logic [MaxTxns-1:0][CntWidth-1:0]  bgt;
  // older[i][j]: slot i was accepted before slot j (both occupied)
  logic [MaxTxns-1:0][MaxTxns-1:0]   older;

  logic                  req_hs, cmpl, unexp, ovf, to_any, fault, do_alloc, found;
  logic [MaxTxns-1:0]    match, done, occ_after, occ_next, alloc_oh;
  logic [CntWidth+8:0]   prod;
  logic [CntWidth-1:0]   req_bgt;
  logic [IdWidth-1:0]    to_id, f_id;
  logic [1:0]            f_cause;
  logic [OutW-1:0]       cnt_next;

  always_comb begin
    req_hs = bus.req_valid & bus.req_ready;
    cmpl   = bus.rsp_valid & bus.rsp_ready & ((Mode != 0) | bus.rsp_last);

    for (int i = 0; i < MaxTxns; i++)
      match[i] = cmpl & occ[i] & (sid[i] == bus.rsp_id);

    // keep only the oldest matching slot
    for (int i = 0; i < MaxTxns; i++) begin
      done[i] = match[i];
      for (int j = 0; j < MaxTxns; j++)
        if (match[j] && older[j][i]) done[i] = 1'b0;
    end

    unexp     = cmpl & ~(|match);
    occ_after = occ & ~done;
    // a slot freed this cycle lets the request in, so overflow uses occ_after
    ovf       = req_hs & (&occ_after);

    to_any = 1'b0;
    to_id  = '0;
    for (int i = 0; i < MaxTxns; i++)
      if (!to_any && occ[i] && bgt[i] != '0 && ela[i] == bgt[i] && !done[i]) begin
        to_any = 1'b1;
        to_id  = sid[i];
      end

    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < MaxTxns; i++)
      if (!found && !occ_after[i]) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end

    prod    = {9'd0, budget_i} * {{CntWidth{1'b0}}, ({1'b0, bus.req_len} + 9'd1)};
    req_bgt = (|prod[CntWidth+8:CntWidth]) ? '1 : prod[CntWidth-1:0];

    fault   = to_any | unexp | ovf;
    f_cause = to_any ? 2'b01 : (unexp ? 2'b10 : 2'b11);
    f_id    = to_any ? to_id : (unexp ? bus.rsp_id : bus.req_id);

    do_alloc = req_hs & ~fault;
    occ_next = fault ? '0 : (occ_after | (do_alloc ? alloc_oh : '0));
    cnt_next = '0;
    for (int i = 0; i < MaxTxns; i++)
      cnt_next = cnt_next + OutW'(occ_next[i]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= MONITOR;
      occ           <= '0;
      reset_req_o   <= 1'b0;
      irq_o         <= 1'b0;
      irq_cause_o   <= '0;
      irq_id_o      <= '0;
      full_o        <= 1'b0;
      outstanding_o <= '0;
    end else begin
      irq_o <= 1'b0;
      case (state)
        MONITOR: begin
          occ           <= occ_next;
          full_o        <= &occ_next;
          outstanding_o <= cnt_next;
          for (int i = 0; i < MaxTxns; i++) begin
            if (do_alloc && alloc_oh[i]) begin
              sid[i] <= bus.req_id;
              ela[i] <= '0;
              bgt[i] <= req_bgt;
              // every slot still held is older than the newcomer
              for (int j = 0; j < MaxTxns; j++) begin
                older[j][i] <= occ_after[j];
                older[i][j] <= 1'b0;
              end
            end else if (ela[i] != '1) begin
              ela[i] <= ela[i] + 1'b1;
            end
          end
          if (fault) begin
            state       <= FAULT;
            reset_req_o <= 1'b1;
            irq_o       <= 1'b1;
            irq_cause_o <= f_cause;
            irq_id_o    <= f_id;
          end
        end
        FAULT: begin
          if (reset_clear_i) begin
            state       <= MONITOR;
            reset_req_o <= 1'b0;
          end
        end
        default: state <= MONITOR;
      endcase
    end
  end

`ifdef TXN_GUARD_LATENCY_EN
  logic [CntWidth-1:0] cmpl_lat;
  logic                cmpl_hit;

  always_comb begin
    cmpl_lat = '0;
    for (int i = 0; i < MaxTxns; i++)
      if (done[i]) cmpl_lat = (ela[i] == '1) ? ela[i] : ela[i] + 1'b1;
    cmpl_hit = (state == MONITOR) & (|done);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      latency_o       <= '0;
      latency_valid_o <= 1'b0;
      max_latency_o   <= '0;
    end else begin
      latency_valid_o <= cmpl_hit;
      if (cmpl_hit) begin
        latency_o <= cmpl_lat;
        if (cmpl_lat > max_latency_o) max_latency_o <= cmpl_lat;
      end
    end
  end
`else
  assign latency_o       = '0;
  assign latency_valid_o = 1'b0;
  assign max_latency_o   = '0;
`endif

endmodule
